// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port single-outstanding memory bus arbiter
// Data port has priority; a starvation counter forces fetch through.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iram_req,
  input  logic [XLEN-1:0]   iram_addr,
  input  logic              iram_flush,
  output logic              iram_ready,
  output logic              iram_rvalid,
  output logic [XLEN-1:0]   iram_rdata,
  input  logic              dram_req,
  input  logic              dram_write,
  input  logic [XLEN/8-1:0] dram_wstrb,
  input  logic [XLEN-1:0]   dram_addr,
  input  logic [XLEN-1:0]   dram_wdata,
  output logic              dram_ready,
  output logic              dram_rvalid,
  output logic [XLEN-1:0]   dram_rdata,
  output logic              bus_req,
  output logic              bus_write,
  output logic [XLEN/8-1:0] bus_wstrb,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_nx;
  logic            owner, owner_nx;
  logic            drop, drop_nx;
  logic [CW-1:0]   starve_cnt, starve_cnt_nx;

  logic issue_win;
  logic resp;
  logic grant_if;
  logic accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      drop       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      drop       <= drop_nx;
      starve_cnt <= starve_cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    drop_nx       = drop;
    starve_cnt_nx = starve_cnt;
    bus_req       = 1'b0;
    bus_write     = 1'b0;
    bus_wstrb     = '0;
    bus_addr      = '0;
    bus_wdata     = '0;
    iram_ready    = 1'b0;
    dram_ready    = 1'b0;
    iram_rvalid   = 1'b0;
    dram_rvalid   = 1'b0;

    // rst gating keeps the bus quiet while the asynchronous reset is held
    resp      = !rst && (state == WAIT) && bus_rvalid;
    issue_win = !rst && ((state == IDLE) || resp);
    grant_if  = iram_req && (!dram_req || (starve_cnt == CW'(STARVE_LIMIT)));

    bus_req = issue_win && (iram_req || dram_req);
    if (grant_if) begin
      bus_addr = iram_addr;
    end else begin
      bus_write = dram_write;
      bus_wstrb = dram_wstrb;
      bus_addr  = dram_addr;
      bus_wdata = dram_wdata;
    end
    accept     = bus_req && bus_ready;
    iram_ready = accept && grant_if;
    dram_ready = accept && !grant_if;

    if (resp) begin
      dram_rvalid = owner;
      iram_rvalid = !owner && !(drop || iram_flush);
    end

    if (accept) begin
      state_nx = WAIT;
      owner_nx = !grant_if;
      drop_nx  = 1'b0;
    end else if (resp) begin
      state_nx = IDLE;
      drop_nx  = 1'b0;
    end else if ((state == WAIT) && !owner && iram_flush) begin
      drop_nx = 1'b1;
    end

    if (!iram_req || iram_ready) begin
      starve_cnt_nx = '0;
    end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
      starve_cnt_nx = starve_cnt + 1'b1;
    end
  end

  assign iram_rdata = bus_rdata;
  assign dram_rdata = bus_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - cycle-table checks for mem_arbiter
// Each row is one clock: inputs plus hand-computed outputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iram_req, iram_flush, iram_ready, iram_rvalid;
  logic [31:0] iram_addr, iram_rdata;
  logic        dram_req, dram_write, dram_ready, dram_rvalid;
  logic [3:0]  dram_wstrb;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;
  logic        bus_req, bus_write, bus_ready, bus_rvalid;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .iram_req(iram_req), .iram_addr(iram_addr), .iram_flush(iram_flush),
    .iram_ready(iram_ready), .iram_rvalid(iram_rvalid), .iram_rdata(iram_rdata),
    .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_ready(dram_ready),
    .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .bus_req(bus_req), .bus_write(bus_write), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // flags = {bus_req, bus_write, iram_ready, dram_ready, iram_rvalid, dram_rvalid}
  typedef struct {
    logic        ir, fl, dr, dw;
    logic [31:0] da;
    logic        br, brv;
    logic [31:0] rd;
    logic [5:0]  flags;
    logic [31:0] ea;
    logic [3:0]  ews;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic ir, logic fl, logic dr, logic dw, logic [31:0] da,
                              logic br, logic brv, logic [31:0] rd,
                              logic [5:0] flags, logic [31:0] ea, logic [3:0] ews);
    vec_t v;
    v.ir = ir; v.fl = fl; v.dr = dr; v.dw = dw; v.da = da;
    v.br = br; v.brv = brv; v.rd = rd;
    v.flags = flags; v.ea = ea; v.ews = ews;
    return v;
  endfunction

  function automatic logic [5:0] act_flags();
    return {bus_req, bus_write, iram_ready, dram_ready, iram_rvalid, dram_rvalid};
  endfunction

  task automatic check_flags(string name, logic [5:0] exp);
    checks++;
    if (act_flags() !== exp) begin
      errors++;
      $display("FAIL %s: flags got %b want %b", name, act_flags(), exp);
    end
  endtask

  task automatic apply(int idx, vec_t v);
    logic [31:0] ewd;
    iram_req   = v.ir;
    iram_flush = v.fl;
    dram_req   = v.dr;
    dram_write = v.dw;
    dram_wstrb = v.dw ? 4'h3 : 4'h0;
    dram_wdata = v.dw ? 32'h55AA : 32'h0;
    dram_addr  = v.da;
    bus_ready  = v.br;
    bus_rvalid = v.brv;
    bus_rdata  = v.rd;
    #2;
    check_flags($sformatf("row%0d", idx), v.flags);
    if (v.flags[5]) begin
      ewd = v.flags[4] ? 32'h55AA : 32'h0;
      checks++;
      if (bus_addr !== v.ea || bus_wstrb !== v.ews || bus_wdata !== ewd) begin
        errors++;
        $display("FAIL row%0d_bus: addr/wstrb/wdata got %h/%h/%h want %h/%h/%h",
                 idx, bus_addr, bus_wstrb, bus_wdata, v.ea, v.ews, ewd);
      end
    end
    if (v.flags[1] || v.flags[0]) begin
      checks++;
      if ((v.flags[1] ? iram_rdata : dram_rdata) !== v.rd) begin
        errors++;
        $display("FAIL row%0d_rdata: got %h/%h want %h", idx, iram_rdata, dram_rdata, v.rd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    iram_addr = 32'h100;
    iram_req = 1'b1; iram_flush = 1'b0;
    dram_req = 1'b1; dram_write = 1'b0; dram_wstrb = 4'h0;
    dram_addr = 32'h0; dram_wdata = 32'h0;
    bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0;
    #2;
    check_flags("reset_outputs", 6'b000000);
    iram_req = 1'b0; dram_req = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // single fetch
    vq.push_back(mk(1,0,0,0,32'h0,  1,0,32'h0,        6'b101000,32'h100,4'h0));
    vq.push_back(mk(0,0,0,0,32'h0,  1,0,32'h0,        6'b000000,32'h0,  4'h0));
    vq.push_back(mk(0,0,0,0,32'h0,  1,1,32'hDEADBEEF, 6'b000010,32'h0,  4'h0));
    // collision: store wins, fetch granted on its ack
    vq.push_back(mk(1,0,1,1,32'h204,1,0,32'h0,        6'b110100,32'h204,4'h3));
    vq.push_back(mk(1,0,0,0,32'h0,  1,1,32'hCAFE0001, 6'b101001,32'h100,4'h0));
    vq.push_back(mk(0,0,0,0,32'h0,  1,1,32'h11111111, 6'b000010,32'h0,  4'h0));
    // starvation: fetch forced through on its 5th pending cycle
    vq.push_back(mk(1,0,1,0,32'h300,1,0,32'h0,        6'b100100,32'h300,4'h0));
    vq.push_back(mk(1,0,1,0,32'h300,1,1,32'h3001,     6'b100101,32'h300,4'h0));
    vq.push_back(mk(1,0,1,0,32'h300,1,1,32'h3002,     6'b100101,32'h300,4'h0));
    vq.push_back(mk(1,0,1,0,32'h300,1,1,32'h3003,     6'b100101,32'h300,4'h0));
    vq.push_back(mk(1,0,1,0,32'h300,1,1,32'h3004,     6'b101001,32'h100,4'h0));
    vq.push_back(mk(0,0,1,0,32'h304,1,1,32'h1F,       6'b100110,32'h304,4'h0));
    vq.push_back(mk(0,0,0,0,32'h0,  1,1,32'h3005,     6'b000001,32'h0,  4'h0));
    // flush while waiting; data request held outside the issue window
    vq.push_back(mk(1,0,0,0,32'h0,  1,0,32'h0,        6'b101000,32'h100,4'h0));
    vq.push_back(mk(0,1,1,0,32'h400,1,0,32'h0,        6'b000000,32'h0,  4'h0));
    vq.push_back(mk(0,0,1,0,32'h400,1,0,32'h0,        6'b000000,32'h0,  4'h0));
    vq.push_back(mk(0,0,1,0,32'h400,1,1,32'hBAD,      6'b100100,32'h400,4'h0));
    vq.push_back(mk(0,0,0,0,32'h0,  1,1,32'h4001,     6'b000001,32'h0,  4'h0));
    // back-to-back loads
    vq.push_back(mk(0,0,1,0,32'h0,  1,0,32'h0,        6'b100100,32'h0,  4'h0));
    vq.push_back(mk(0,0,1,0,32'h4,  1,1,32'hA0,       6'b100101,32'h4,  4'h0));
    vq.push_back(mk(0,0,1,0,32'h8,  1,1,32'hA4,       6'b100101,32'h8,  4'h0));
    vq.push_back(mk(0,0,0,0,32'h0,  1,1,32'hA8,       6'b000001,32'h0,  4'h0));
    // bus stall, then accept
    vq.push_back(mk(0,0,1,0,32'h10, 0,0,32'h0,        6'b100000,32'h10, 4'h0));
    vq.push_back(mk(0,0,1,0,32'h10, 1,0,32'h0,        6'b100100,32'h10, 4'h0));
    vq.push_back(mk(0,0,0,0,32'h0,  1,1,32'h10D,      6'b000001,32'h0,  4'h0));
    // stray response in IDLE
    vq.push_back(mk(0,0,0,0,32'h0,  1,1,32'hEE,       6'b000000,32'h0,  4'h0));
    // flush on the accept cycle does not drop
    vq.push_back(mk(1,1,0,0,32'h0,  1,0,32'h0,        6'b101000,32'h100,4'h0));
    vq.push_back(mk(0,0,0,0,32'h0,  1,1,32'h77,       6'b000010,32'h0,  4'h0));
    // flush on the response cycle drops it
    vq.push_back(mk(1,0,0,0,32'h0,  1,0,32'h0,        6'b101000,32'h100,4'h0));
    vq.push_back(mk(0,1,0,0,32'h0,  1,1,32'h88,       6'b000000,32'h0,  4'h0));

    foreach (vq[i]) apply(i, vq[i]);

    // reset mid-transaction, then a late response
    iram_flush = 1'b0; dram_req = 1'b0; bus_rvalid = 1'b0; bus_ready = 1'b1;
    iram_req = 1'b1;
    #2;
    check_flags("rst_seq_accept", 6'b101000);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check_flags("rst_seq_held", 6'b000000);
    @(posedge clk); #1;
    rst = 1'b0; iram_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h99;
    #2;
    check_flags("rst_seq_late_rvalid", 6'b000000);
    @(posedge clk); #1;
    bus_rvalid = 1'b0; iram_req = 1'b1;
    #2;
    check_flags("rst_seq_regrant", 6'b101000);
    @(posedge clk); #1;
    iram_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5A;
    #2;
    check_flags("rst_seq_resp", 6'b000010);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
